image_combiner: RTL and testbench

//   Parametrised two-image pixel combiner: streams frames A and B from two external sync-read RAMs, applies a

---
 rtl/image_combiner_if.sv | 29 ++
 rtl/image_combiner.sv | 160 ++++++++++++++++
 tb/tb_image_combiner.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/image_combiner_if.sv
// Bus bundle for image_combiner: control handshake, source-RAM read port and result-RAM write port.
interface image_combiner_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
);
    logic              start;
    logic [2:0]        mode;
    logic              hold;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;
    logic [ADDR_W:0]   sat_count;

    modport slave (
        input  start, mode, hold, rd_data_a, rd_data_b,
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, sat_count
    );

    modport master (
        output start, mode, hold, rd_data_a, rd_data_b,
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done, sat_count
    );
endinterface

// File: rtl/image_combiner.sv
// Two-frame pixel combiner: reads A/B from sync-read RAMs, applies the latched op, writes the result
// two cycles after each read, and counts clamped pixels.
module image_combiner #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6
) (
    input  logic clk,
    input  logic rst,
    image_combiner_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   SAT_MAX   = {1'b1, {ADDR_W{1'b0}}};

    state_t            r_state;
    state_t            w_next;
    logic [2:0]        r_mode;
    logic [ADDR_W-1:0] r_rd_addr;
    logic [ADDR_W-1:0] r_addr1;
    logic              r_v1;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [DATA_W-1:0] r_wr_data;
    logic [ADDR_W:0]   r_sat_count;
    logic              r_busy;
    logic              r_done;
    logic              w_issue;
    logic              w_accept;
    logic [DATA_W:0]   w_op;

    // Returns {clamped, result}; the sum carries one extra bit so add/avg never lose the carry.
    function automatic logic [DATA_W:0] f_combine(input logic [2:0] m,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0]   sum;
        logic [DATA_W-1:0] res;
        logic              sat;
        sum = {1'b0, a} + {1'b0, b};
        res = a;
        sat = 1'b0;
        case (m)
            3'd0: res = sum[DATA_W-1:0];
            3'd1: begin
                if (sum[DATA_W]) begin
                    res = {DATA_W{1'b1}};
                    sat = 1'b1;
                end else begin
                    res = sum[DATA_W-1:0];
                end
            end
            3'd2: res = (a >= b) ? (a - b) : (b - a);
            3'd3: res = sum[DATA_W:1];
            3'd4: begin
                if (a < b) begin
                    res = {DATA_W{1'b0}};
                    sat = 1'b1;
                end else begin
                    res = a - b;
                end
            end
            3'd5: res = (a >= b) ? a : b;
            3'd6: res = (a <= b) ? a : b;
            3'd7: res = a;
            default: res = a;
        endcase
        return {sat, res};
    endfunction

    always_comb begin
        w_issue  = (r_state == S_RUN) && !bus.hold;
        w_accept = (r_state == S_IDLE) && bus.start;
        w_op     = f_combine(r_mode, bus.rd_data_a, bus.rd_data_b);
        w_next   = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_RUN;
                else           w_next = S_IDLE;
            end
            S_RUN: begin
                if (w_issue && (r_rd_addr == LAST_ADDR)) w_next = S_DRAIN;
                else                                     w_next = S_RUN;
            end
            // Stage 1 empty means the last write is already registered; DONE follows it by one cycle.
            S_DRAIN: begin
                if (!r_v1) w_next = S_DONE;
                else       w_next = S_DRAIN;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= (w_next != S_IDLE);
            r_done  <= (w_next == S_DONE);
        end
    end

    // Read issue: address stops at the last pixel rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mode    <= 3'd0;
            r_rd_addr <= {ADDR_W{1'b0}};
            r_addr1   <= {ADDR_W{1'b0}};
            r_v1      <= 1'b0;
        end else begin
            r_v1 <= w_issue;
            if (w_issue) begin
                r_addr1 <= r_rd_addr;
            end
            if (w_accept) begin
                r_mode    <= bus.mode;
                r_rd_addr <= {ADDR_W{1'b0}};
            end else if (w_issue && (r_rd_addr != LAST_ADDR)) begin
                r_rd_addr <= r_rd_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_en     <= 1'b0;
            r_wr_addr   <= {ADDR_W{1'b0}};
            r_wr_data   <= {DATA_W{1'b0}};
            r_sat_count <= {(ADDR_W+1){1'b0}};
        end else begin
            r_wr_en <= r_v1;
            if (r_v1) begin
                r_wr_addr <= r_addr1;
                r_wr_data <= w_op[DATA_W-1:0];
            end
            if (w_accept) begin
                r_sat_count <= {(ADDR_W+1){1'b0}};
            end else if (r_v1 && w_op[DATA_W] && (r_sat_count != SAT_MAX)) begin
                r_sat_count <= r_sat_count + {{ADDR_W{1'b0}}, 1'b1};
            end
        end
    end

    assign bus.rd_en     = w_issue;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.wr_data   = r_wr_data;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.sat_count = r_sat_count;
endmodule

// File: tb/tb_image_combiner.sv
// Self-checking bench for image_combiner: RAM models, arithmetic reference model, directed and random frames.
module tb_image_combiner;
    localparam int DW   = 8;
    localparam int AW   = 6;
    localparam int NPIX = 1 << AW;
    localparam int MAXV = (1 << DW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;
    int   mem_a [NPIX];
    int   mem_b [NPIX];

    image_combiner_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    image_combiner #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rd_en) begin
            bus.rd_data_a <= DW'(mem_a[bus.rd_addr]);
            bus.rd_data_b <= DW'(mem_b[bus.rd_addr]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int ref_val(input int m, input int a, input int b);
        case (m)
            0: return (a + b) % (MAXV + 1);
            1: return (a + b > MAXV) ? MAXV : a + b;
            2: return (a > b) ? a - b : b - a;
            3: return (a + b) / 2;
            4: return (a < b) ? 0 : a - b;
            5: return (a > b) ? a : b;
            6: return (a < b) ? a : b;
            default: return a;
        endcase
    endfunction

    function automatic int ref_sat(input int m, input int a, input int b);
        return ((m == 1 && a + b > MAXV) || (m == 4 && a < b)) ? 1 : 0;
    endfunction

    task automatic fill(input int kind, input int ca, input int cb);
        for (int i = 0; i < NPIX; i++) begin
            case (kind)
                0: begin mem_a[i] = ca; mem_b[i] = cb; end
                1: begin mem_a[i] = i; mem_b[i] = NPIX - 1 - i; end
                default: begin mem_a[i] = int'($urandom_range(0, MAXV)); mem_b[i] = int'($urandom_range(0, MAXV)); end
            endcase
        end
    endtask

    // hold_kind: 0 none, 1 every other cycle, 2 random
    task automatic run_frame(input int m, input int hold_kind, input bit poke_start);
        int n = 0, first_rd = -1, first_wr = -1, last_wr = -1, done_n = -1;
        int ndone = 0, nwr = 0, nrd = 0, exp_addr = 0, exp_sat = 0;
        for (int i = 0; i < NPIX; i++) exp_sat += ref_sat(m, mem_a[i], mem_b[i]);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 3'(m);
        bus.hold  = 1'b0;
        while (done_n < 0 && n < 400) begin
            @(negedge clk);
            n++;
            bus.start = poke_start && (n == 10);
            bus.mode  = 3'($urandom_range(0, 7));
            if (bus.wr_en) begin
                if (first_wr < 0) first_wr = n;
                last_wr = n;
                nwr++;
                chk("wr_addr", 32'(bus.wr_addr), 32'(exp_addr));
                chk("wr_data", 32'(bus.wr_data), 32'(ref_val(m, mem_a[bus.wr_addr], mem_b[bus.wr_addr])));
                exp_addr++;
            end
            if (bus.done) begin
                ndone++;
                done_n = n;
                chk("busy_at_done", 32'(bus.busy), 32'd1);
                chk("sat_at_done", 32'(bus.sat_count), 32'(exp_sat));
            end
            case (hold_kind)
                0:       bus.hold = 1'b0;
                1:       bus.hold = (n % 2 == 0);
                default: bus.hold = 1'($urandom_range(0, 1));
            endcase
            #1;
            if (bus.rd_en) begin
                nrd++;
                if (first_rd < 0) first_rd = n;
            end
        end
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        chk("done_count", 32'(ndone), 32'd1);
        chk("write_count", 32'(nwr), 32'(NPIX));
        chk("read_count", 32'(nrd), 32'(NPIX));
        chk("rd_to_wr_latency", 32'(first_wr - first_rd), 32'd2);
        chk("wr_to_done", 32'(done_n - last_wr), 32'd1);
        if (hold_kind == 0) chk("frame_time", 32'(done_n), 32'(NPIX + 3));
        @(negedge clk);
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("done_pulse_width", 32'(bus.done), 32'd0);
        chk("sat_holds", 32'(bus.sat_count), 32'(exp_sat));
    endtask

    initial begin
        bit found;
        bus.start = 1'b0;
        bus.mode  = 3'd0;
        bus.hold  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_rd_en", 32'(bus.rd_en), 32'd0);
        chk("rst_wr_en", 32'(bus.wr_en), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_sat", 32'(bus.sat_count), 32'd0);
        chk("rst_wr_data", 32'(bus.wr_data), 32'd0);
        chk("rst_rd_addr", 32'(bus.rd_addr), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        fill(0, 200, 100); run_frame(0, 0, 1'b0);
        fill(0, 200, 100); run_frame(1, 0, 1'b0);
        fill(0, 10, 250);  run_frame(4, 0, 1'b0);
        fill(0, 10, 250);  run_frame(2, 0, 1'b0);
        fill(0, 255, 255); run_frame(3, 0, 1'b0);
        fill(0, 3, 4);     run_frame(3, 0, 1'b1);
        fill(1, 0, 0);     run_frame(5, 0, 1'b0);
        fill(1, 0, 0);     run_frame(6, 0, 1'b0);
        fill(1, 0, 0);     run_frame(7, 0, 1'b0);
        fill(2, 0, 0);     run_frame(2, 1, 1'b0);
        for (int m = 0; m < 8; m++) begin
            fill(2, 0, 0);
            run_frame(m, 2, m == 3);
        end

        // Abort mid-frame at the write of pixel 20, then restart cleanly.
        fill(2, 0, 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.mode  = 3'd1;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.wr_en && bus.wr_addr == AW'(20)) found = 1'b1;
        end
        chk("abort_reached_px20", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        chk("abort_wr_en", 32'(bus.wr_en), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_rd_en", 32'(bus.rd_en), 32'd0);
        chk("abort_sat", 32'(bus.sat_count), 32'd0);
        chk("abort_wr_addr", 32'(bus.wr_addr), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_no_write", 32'(bus.wr_en), 32'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        fill(2, 0, 0);
        run_frame(1, 0, 1'b0);
        fill(2, 0, 0);
        run_frame(4, 2, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
